bandit_round_ctrl: RTL and testbench
====================================

# bandit_round_ctrl

Round sequencer for the one-arm bandit game. Converts the player's debounced start/stop button pulses into the turn, reel-stop and score strobes consumed by the `Score` block and the three reel counters. It then collects `Score`'s `pass_p`/`lose_p` verdict. It sits between the button front-end and `Score`/reel counters, and owns all per-round sequencing.

## Interface
Parameters:
- `AUTO_STOP_CYC`, 50_000_000: cycles a reel may spin before it is stopped automatically.
- `SETTLE_CYC`, 4: cycles between the third reel stop and `score_sign`. Must be ≥1.
- `RESULT_CYC`, 8: cycles the verdict window stays open after `score_sign`. Must be ≥1.

Ports:
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_p` in 1: one-cycle start-button pulse.
- `stop_p` in 1: one-cycle stop-button pulse.
- `pass_p` in 1: win pulse from `Score`.
- `lose_p` in 1: credit-exhausted pulse from `Score`.
- `reel_run` out 3: reel counter enables; bit i enables reel i+1.
- `turn_p` out 1: one-cycle round-start strobe to `Score`.
- `refresh` out 2: index (1..3) of the most recently stopped reel; 0 means none.
- `ref_sign` out 1: one-cycle strobe qualifying a new `refresh` value.
- `score_sign` out 1: one-cycle strobe telling `Score` to evaluate `number1..3`.
- `busy` out 1: high in every state except IDLE and OVER.
- `win` out 1: set by `pass_p` in RESULT; cleared at the next START.
- `game_over` out 1: sticky once set; cleared only by reset.
- `round_cnt` out 8: count of rounds started; wraps from 255 to 0.

## Operation
- FSM states: IDLE → START → SPIN1 → SPIN2 → SPIN3 → SETTLE → SCORE → RESULT → IDLE, plus a terminal state OVER.
- IDLE: `start_p` moves to START. `stop_p` is ignored.
- START (1 cycle):
  - `turn_p`=1 and `reel_run`=3'b111.
  - `round_cnt`+1 and `win`=0.
  - `refresh`=0.
  - Next state is SPIN1.
- SPINn (n=1..3): a stop event is `stop_p`, or the timer reaching `AUTO_STOP_CYC`-1. On a stop event:
  - clear `reel_run[n-1]`;
  - set `refresh`=n;
  - pulse `ref_sign` for 1 cycle;
  - advance to the next state.
- The stop timer clears on entry to each SPINn state.
- `stop_p` and a timeout in the same cycle produce exactly one stop.
- SETTLE: wait `SETTLE_CYC` cycles, then go to SCORE.
- SCORE (1 cycle): `score_sign`=1, then go to RESULT.
- RESULT: open for at most `RESULT_CYC` cycles.
  - `lose_p` → OVER; this has priority over a simultaneous `pass_p`.
  - `pass_p` → `win`=1, then IDLE.
  - Window expires with neither → IDLE.
- OVER: `game_over`=1, `reel_run`=0, all strobes 0, every input ignored.
- `start_p` while `busy`: ignored. It is not queued.
- `pass_p`/`lose_p` outside RESULT: ignored.
- Reset (asynchronous, at any point including mid-round):
  - state=IDLE;
  - `reel_run`=0, `refresh`=0;
  - `turn_p`, `ref_sign` and `score_sign`=0;
  - `busy`, `win`, `game_over`=0;
  - `round_cnt`=0;
  - stop timer=0.

## Timing
- All outputs are registered.
- `start_p` at cycle N → `turn_p`=1 and `reel_run`=111 in cycle N+1; SPIN1 from N+2.
- `stop_p` at cycle M in SPINn → `reel_run`, `refresh` and `ref_sign` update in M+1.
- Third stop at cycle K → `score_sign` high in cycle K+1+`SETTLE_CYC`.
- Verdict pulse at cycle R → `win` or `game_over` visible at R+1; `busy` low at R+1.
- Timeout → stop takes effect exactly `AUTO_STOP_CYC` cycles after SPINn entry.

## Configuration
- `BANDIT_AUTO_STOP_EN` defined: the auto-stop timer is present, as described above.
- `BANDIT_AUTO_STOP_EN` undefined:
  - the timer is not instantiated;
  - only `stop_p` stops reels;
  - `AUTO_STOP_CYC` is unused.

## Structure
- `bandit_pkg` holds:
  - the FSM state enum;
  - the `refresh` codes REEL_NONE/REEL1/REEL2/REEL3;
  - the default timing constants.
- One sub-module, `stop_timer`:
  - a clear-on-entry cycle counter producing a one-cycle `expire` pulse;
  - instantiated only under `BANDIT_AUTO_STOP_EN`.

## Test plan
- Reset release, then `start_p` pulse → 1-cycle `turn_p`, `reel_run`=111, `round_cnt`=1, `busy`=1.
- Three `stop_p` pulses 10 cycles apart → `reel_run` steps 110, 100, 000; `refresh` steps 1, 2, 3, each with one `ref_sign`. `score_sign` appears 1+`SETTLE_CYC` cycles after the third stop.
- `pass_p` 2 cycles after `score_sign` → `win`=1, state IDLE. `lose_p` together with `pass_p` → `game_over`=1, `win`=0, and later `start_p` is ignored.
- With macro defined and `AUTO_STOP_CYC`=20, no `stop_p` → each reel stops 20 cycles after its SPIN entry. `stop_p` coinciding with a timeout → only one reel stops.
- `start_p` during SPIN2, `stop_p` in IDLE, and `lose_p` outside RESULT → no output change.
- `rst_n` low in SPIN2 → all outputs at reset values immediately (asynchronously). After release, `start_p` restarts with `round_cnt`=1.

Source files
------------

// File: rtl/bandit_pkg.sv
// Shared types and constants for the bandit round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bandit_pkg;

    // Round sequencer states. The encoding is internal to the controller.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_SPIN1,
        ST_SPIN2,
        ST_SPIN3,
        ST_SETTLE,
        ST_SCORE,
        ST_RESULT,
        ST_OVER
    } round_state_t;

    // Codes carried on refresh: which reel stopped most recently.
    localparam logic [1:0] REEL_NONE = 2'd0;
    localparam logic [1:0] REEL1     = 2'd1;
    localparam logic [1:0] REEL2     = 2'd2;
    localparam logic [1:0] REEL3     = 2'd3;

    // Default timing, in core clock cycles.
    localparam int unsigned DEF_AUTO_STOP_CYC = 50_000_000;
    localparam int unsigned DEF_SETTLE_CYC    = 4;
    localparam int unsigned DEF_RESULT_CYC    = 8;

endpackage

// File: rtl/stop_timer.sv
// Reel auto-stop timer: counts cycles since clear, flags the LIMIT-th cycle.
// Latency: expire is combinational from the count, high in the LIMIT-th enabled cycle after clear.
// Backpressure: none; the counter holds at LIMIT-1 until cleared.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart count at 0 on the next edge (wins over en)
//   en         : count this cycle
//   expire     : count has reached LIMIT-1 while enabled
module stop_timer #(
    parameter int unsigned LIMIT = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    // Combinational so the controller can register the stop on the same edge
    // that a manual stop would be registered on.
    assign expire = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bandit_round_ctrl.sv
// One-arm bandit round sequencer: buttons -> turn/reel-stop/score strobes, collects verdict.
// Latency: every output registered, one cycle after the input event that causes it.
// Backpressure: none; start_p while busy and verdict pulses outside RESULT are dropped.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_p, stop_p     : one-cycle button pulses
//   pass_p, lose_p      : verdict pulses from Score
//   reel_run[2:0]       : reel counter enables (bit i -> reel i+1)
//   turn_p, ref_sign,
//   score_sign          : one-cycle strobes
//   refresh[1:0]        : most recently stopped reel (0 = none)
//   busy, win,
//   game_over           : status
//   round_cnt[7:0]      : rounds started, wrapping
// Build option: define BANDIT_AUTO_STOP_EN to stop a reel automatically after AUTO_STOP_CYC cycles.
module bandit_round_ctrl
    import bandit_pkg::*;
#(
    parameter int unsigned AUTO_STOP_CYC = DEF_AUTO_STOP_CYC,
    parameter int unsigned SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int unsigned RESULT_CYC    = DEF_RESULT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       pass_p,
    input  logic       lose_p,
    output logic [2:0] reel_run,
    output logic       turn_p,
    output logic [1:0] refresh,
    output logic       ref_sign,
    output logic       score_sign,
    output logic       busy,
    output logic       win,
    output logic       game_over,
    output logic [7:0] round_cnt
);

    // SETTLE and RESULT never overlap, so one down-the-line counter serves both.
    localparam int unsigned PMAX = (SETTLE_CYC > RESULT_CYC) ? SETTLE_CYC : RESULT_CYC;
    localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    round_state_t  state;
    logic [PW-1:0] phase_cnt;
    logic          in_spin;
    logic          timeout;
    logic          stop_evt;

    assign in_spin = (state == ST_SPIN1) || (state == ST_SPIN2) || (state == ST_SPIN3);

`ifdef BANDIT_AUTO_STOP_EN
    // Held clear outside the spin states and on each stop, so the count starts
    // at 0 in the first cycle of every SPINn.
    stop_timer #(
        .LIMIT (AUTO_STOP_CYC)
    ) u_stop_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_spin || stop_evt),
        .en     (in_spin),
        .expire (timeout)
    );
`else
    // Without the timer the parameter has no effect; keep it referenced.
    logic unused_auto_stop;
    assign unused_auto_stop = ^AUTO_STOP_CYC;
    assign timeout          = 1'b0;
`endif

    // A manual stop coinciding with a timeout is still a single stop event.
    assign stop_evt = in_spin && (stop_p || timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            reel_run   <= '0;
            refresh    <= REEL_NONE;
            turn_p     <= 1'b0;
            ref_sign   <= 1'b0;
            score_sign <= 1'b0;
            busy       <= 1'b0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            round_cnt  <= '0;
        end else begin
            turn_p     <= 1'b0;
            ref_sign   <= 1'b0;
            score_sign <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_p) begin
                        state     <= ST_START;
                        turn_p    <= 1'b1;
                        reel_run  <= 3'b111;
                        round_cnt <= round_cnt + 8'd1;
                        win       <= 1'b0;
                        refresh   <= REEL_NONE;
                        busy      <= 1'b1;
                    end
                end
                ST_START: state <= ST_SPIN1;
                ST_SPIN1: begin
                    if (stop_evt) begin
                        reel_run[0] <= 1'b0;
                        refresh     <= REEL1;
                        ref_sign    <= 1'b1;
                        state       <= ST_SPIN2;
                    end
                end
                ST_SPIN2: begin
                    if (stop_evt) begin
                        reel_run[1] <= 1'b0;
                        refresh     <= REEL2;
                        ref_sign    <= 1'b1;
                        state       <= ST_SPIN3;
                    end
                end
                ST_SPIN3: begin
                    if (stop_evt) begin
                        reel_run[2] <= 1'b0;
                        refresh     <= REEL3;
                        ref_sign    <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (phase_cnt == PW'(SETTLE_CYC - 1)) begin
                        score_sign <= 1'b1;
                        state      <= ST_SCORE;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                ST_SCORE: begin
                    phase_cnt <= '0;
                    state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    // lose_p is checked first so it wins over a simultaneous pass_p.
                    if (lose_p) begin
                        game_over <= 1'b1;
                        reel_run  <= '0;
                        busy      <= 1'b0;
                        state     <= ST_OVER;
                    end else if (pass_p) begin
                        win   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (phase_cnt == PW'(RESULT_CYC - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                ST_OVER: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bandit_round_ctrl.sv
// Bench for bandit_round_ctrl: directed table, corner sequences, random run against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bandit_round_ctrl;

    localparam int AUTO = 20;
    localparam int SET  = 4;
    localparam int RES  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_p = 1'b0, stop_p = 1'b0, pass_p = 1'b0, lose_p = 1'b0;
    logic [2:0] reel_run;
    logic       turn_p, ref_sign, score_sign, busy, win, game_over;
    logic [1:0] refresh;
    logic [7:0] round_cnt;

    int nvec = 0;
    int nmis = 0;

    bandit_round_ctrl #(
        .AUTO_STOP_CYC (AUTO),
        .SETTLE_CYC    (SET),
        .RESULT_CYC    (RES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_p    (start_p),
        .stop_p     (stop_p),
        .pass_p     (pass_p),
        .lose_p     (lose_p),
        .reel_run   (reel_run),
        .turn_p     (turn_p),
        .refresh    (refresh),
        .ref_sign   (ref_sign),
        .score_sign (score_sign),
        .busy       (busy),
        .win        (win),
        .game_over  (game_over),
        .round_cnt  (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {reel_run, refresh, turn_p, ref_sign, score_sign, busy, win, game_over, round_cnt};
    endfunction

    // ---------------- timeline reference model ----------------
    // A round is tracked by the cycle numbers at which things must happen,
    // not by a state machine: when the current reel may first be stopped,
    // and when score_sign is due.
    int         cyc = 0;
    bit         m_over, m_round;
    int         stops, t_spin, t_score;
    logic [2:0] m_reel;
    logic [1:0] m_ref;
    bit         m_turn, m_rsig, m_ssig, m_busy, m_win;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_over = 0; m_round = 0; stops = 0; t_spin = 0; t_score = 0;
        m_reel = '0; m_ref = '0; m_turn = 0; m_rsig = 0; m_ssig = 0;
        m_busy = 0; m_win = 0; m_cnt = '0;
    endtask

    function automatic logic [18:0] model_vec();
        return {m_reel, m_ref, m_turn, m_rsig, m_ssig, m_busy, m_win, m_over, m_cnt};
    endfunction

    // Inputs present in cycle cyc -> expected outputs for cycle cyc+1.
    task automatic model_step(input bit st, input bit sp, input bit pa, input bit lo);
        bit ev;
        m_turn = 0; m_rsig = 0; m_ssig = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_over) return;
        if (!m_round) begin
            if (st) begin
                m_round = 1; m_turn = 1; m_reel = 3'b111; m_ref = 2'd0;
                m_cnt = m_cnt + 8'd1; m_win = 0; m_busy = 1;
                stops = 0; t_spin = cyc + 2;
            end
        end else if (stops < 3) begin
            if (cyc >= t_spin) begin
                ev = sp;
`ifdef BANDIT_AUTO_STOP_EN
                if (cyc - t_spin == AUTO - 1) ev = 1;
`endif
                if (ev) begin
                    m_reel[stops] = 1'b0;
                    stops++;
                    m_ref  = 2'(stops);
                    m_rsig = 1;
                    if (stops < 3) t_spin = cyc + 1;
                    else           t_score = cyc + 1 + SET;
                end
            end
        end else begin
            if (cyc == t_score - 1) begin
                m_ssig = 1;
            end else if (cyc > t_score) begin
                if (lo) begin
                    m_over = 1; m_busy = 0; m_round = 0;
                end else if (pa) begin
                    m_win = 1; m_busy = 0; m_round = 0;
                end else if (cyc == t_score + RES) begin
                    m_busy = 0; m_round = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance, compare against the model mid-cycle.
    task automatic tick(input bit st, input bit sp, input bit pa, input bit lo);
        start_p = st; stop_p = sp; pass_p = pa; lose_p = lo;
        @(posedge clk);
        model_step(st, sp, pa, lo);
        cyc++;
        @(negedge clk);
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit st, sp, pa, lo;
        logic [2:0] reel;
        logic [1:0] rf;
        bit turn, rs, ss, bsy, wn, ovr;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input bit st, sp, pa, lo, input logic [2:0] reel, input logic [1:0] rf,
                                input bit turn, rs, ss, bsy, wn, ovr, input logic [7:0] cnt);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.lo = lo; v.reel = reel; v.rf = rf;
        v.turn = turn; v.rs = rs; v.ss = ss; v.bsy = bsy; v.wn = wn; v.ovr = ovr; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int n;
        // Row i: inputs in cycle i, expected outputs in cycle i+1.
        //             st sp pa lo reel  rf  tu rs ss by wn ov cnt
        tbl[0]  = mk(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(0, 1, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 8'd0); // stop in IDLE
        tbl[2]  = mk(0, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 8'd0); // lose in IDLE
        tbl[3]  = mk(1, 0, 0, 0, 3'd7, 2'd0, 1, 0, 0, 1, 0, 0, 8'd1); // START
        tbl[4]  = mk(0, 0, 0, 0, 3'd7, 2'd0, 0, 0, 0, 1, 0, 0, 8'd1); // SPIN1
        tbl[5]  = mk(0, 1, 0, 0, 3'd6, 2'd1, 0, 1, 0, 1, 0, 0, 8'd1);
        tbl[6]  = mk(0, 0, 0, 0, 3'd6, 2'd1, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[7]  = mk(1, 0, 0, 0, 3'd6, 2'd1, 0, 0, 0, 1, 0, 0, 8'd1); // start in SPIN2
        tbl[8]  = mk(0, 0, 0, 1, 3'd6, 2'd1, 0, 0, 0, 1, 0, 0, 8'd1); // lose in SPIN2
        tbl[9]  = mk(0, 1, 0, 0, 3'd4, 2'd2, 0, 1, 0, 1, 0, 0, 8'd1);
        tbl[10] = mk(0, 1, 0, 0, 3'd0, 2'd3, 0, 1, 0, 1, 0, 0, 8'd1); // third stop
        tbl[11] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[12] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[13] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[14] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 1, 1, 0, 0, 8'd1); // score_sign
        tbl[15] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[16] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 1, 0, 0, 8'd1);
        tbl[17] = mk(0, 0, 1, 0, 3'd0, 2'd3, 0, 0, 0, 0, 1, 0, 8'd1); // pass
        tbl[18] = mk(0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 0, 0, 1, 0, 8'd1);

        model_reset();
        #1;
        chk("reset", 32'(dut_vec()), 32'd0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].lo);
            chk($sformatf("tbl%0d", i), 32'(dut_vec()),
                32'({tbl[i].reel, tbl[i].rf, tbl[i].turn, tbl[i].rs, tbl[i].ss,
                     tbl[i].bsy, tbl[i].wn, tbl[i].ovr, tbl[i].cnt}));
        end

        // lose_p with pass_p: game over, win cleared by START, later start ignored.
        tick(1, 0, 0, 0);
        chk("win_clr", 32'(win), 32'd0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        n = 0;
        while (score_sign !== 1'b1 && n < 50) begin
            tick(0, 0, 0, 0);
            n++;
        end
        chk("settle_lat", 32'(n), 32'(SET));
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        chk("lose_prio", 32'({win, game_over, busy}), 32'b010);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("over_start", 32'({turn_p, busy, game_over, round_cnt}), 32'({3'b001, 8'd2}));

        // Auto-stop latency and a manual stop landing on the timeout cycle.
        do_reset();
        tick(1, 0, 0, 0);
`ifdef BANDIT_AUTO_STOP_EN
        n = 0;
        while (ref_sign !== 1'b1 && n < 100) begin
            tick(0, 0, 0, 0);
            n++;
        end
        chk("auto_lat", 32'(n), 32'(AUTO + 1));
`else
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
`endif
        repeat (AUTO - 1) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("coincide", 32'({reel_run, refresh, ref_sign}), 32'({3'b100, 2'd2, 1'b1}));
        tick(0, 0, 0, 0);
        chk("one_stop", 32'({reel_run, refresh, ref_sign}), 32'({3'b100, 2'd2, 1'b0}));

        // Asynchronous reset in SPIN2, then a fresh round restarts the count.
        do_reset();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(dut_vec()), 32'd0);
        model_reset();
        tick(0, 0, 0, 0);
        rst_n = 1'b1;
        tick(1, 0, 0, 0);
        chk("restart", 32'({turn_p, busy, reel_run, round_cnt}), 32'({2'b11, 3'b111, 8'd1}));

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 2);
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
